// File: rtl/apb_master.sv
// APB (AMBA3-style) requester: turns one-at-a-time valid/ready commands into
// SETUP/ACCESS bus cycles and returns a one-cycle response pulse.
// Optional feature macro: APB_TIMEOUT_EN aborts an ACCESS phase after
// TIMEOUT_CYCLES wait cycles with an error response.
module apb_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              psel_s;
    logic              penable_s;
    logic              pwrite_s;
    logic [ADDR_W-1:0] paddr_s;
    logic [DATA_W-1:0] pwdata_s;
    logic              rsp_valid_s;
    logic [DATA_W-1:0] rsp_rdata_s;
    logic              rsp_err_s;
    logic              timeout_s;

    // Only the command handshake is combinational: a new command is taken in IDLE.
    assign cmd_ready = (state_r == ST_IDLE);

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_r;

    // The last permitted wait cycle is reached when TIMEOUT_CYCLES-1 waits are behind us.
    assign timeout_s = (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait-state counter: cleared while in SETUP, advances on every stalled ACCESS cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_SETUP) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_ACCESS) && !PREADY) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end
`else
    logic unused_timeout_s;

    // Without the timeout feature ACCESS waits for PREADY indefinitely.
    assign timeout_s        = 1'b0;
    assign unused_timeout_s = (TIMEOUT_CYCLES != 32'sd0);
`endif

    // Next-state and next-output logic; bus fields hold unless a command is captured.
    always_comb begin
        state_s     = state_r;
        psel_s      = PSEL;
        penable_s   = PENABLE;
        pwrite_s    = PWRITE;
        paddr_s     = PADDR;
        pwdata_s    = PWDATA;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = rsp_rdata;
        rsp_err_s   = rsp_err;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s   = ST_SETUP;
                    psel_s    = 1'b1;
                    penable_s = 1'b0;
                    pwrite_s  = cmd_write;
                    paddr_s   = cmd_addr;
                    pwdata_s  = cmd_write ? cmd_wdata : {DATA_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s   = ST_ACCESS;
                penable_s = 1'b1;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_s     = ST_IDLE;
                    psel_s      = 1'b0;
                    penable_s   = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = PSLVERR;
                    rsp_rdata_s = PWRITE ? {DATA_W{1'b0}} : PRDATA;
                end else if (timeout_s) begin
                    state_s     = ST_IDLE;
                    psel_s      = 1'b0;
                    penable_s   = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                    rsp_rdata_s = {DATA_W{1'b0}};
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                psel_s    = 1'b0;
                penable_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus immediately and cancels any response.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r   <= ST_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= {ADDR_W{1'b0}};
            PWDATA    <= {DATA_W{1'b0}};
            rsp_valid <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
            rsp_err   <= 1'b0;
        end else begin
            state_r   <= state_s;
            PSEL      <= psel_s;
            PENABLE   <= penable_s;
            PWRITE    <= pwrite_s;
            PADDR     <= paddr_s;
            PWDATA    <= pwdata_s;
            rsp_valid <= rsp_valid_s;
            rsp_rdata <= rsp_rdata_s;
            rsp_err   <= rsp_err_s;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: randomized transfers against a
// transaction-timeline reference model (SETUP, 1+waits ACCESS cycles, response).
// Honours APB_TIMEOUT_EN when the design is built with it.
module tb_apb_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TO     = 16;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;
    logic              PSLVERR;

    int n_vec     = 0;
    int n_miscmp  = 0;

    logic [DATA_W-1:0] last_rdata;
    logic              last_err;

    apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    // Free-running bus clock.
    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One complete transfer with 'waits' stalled ACCESS cycles; expectations follow the protocol timeline.
    task automatic do_xfer(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input int waits, input logic [DATA_W-1:0] rd, input logic er);
        logic [DATA_W-1:0] exp_wd;
        exp_wd = w ? d : 32'h0;
        check_eq("idle_cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
        tick();
        cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = $urandom; cmd_wdata = $urandom;
        check_eq("setup_psel", PSEL, 1'b1);
        check_eq("setup_penable", PENABLE, 1'b0);
        check_eq("setup_paddr", PADDR, a);
        check_eq("setup_pwrite", PWRITE, w);
        check_eq("setup_pwdata", PWDATA, exp_wd);
        check_eq("setup_cmd_ready", cmd_ready, 1'b0);
        check_eq("setup_rsp_valid", rsp_valid, 1'b0);
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
        tick();
        for (int k = 0; k <= waits; k++) begin
            check_eq("access_psel", PSEL, 1'b1);
            check_eq("access_penable", PENABLE, 1'b1);
            check_eq("access_paddr", PADDR, a);
            check_eq("access_pwrite", PWRITE, w);
            check_eq("access_pwdata", PWDATA, exp_wd);
            check_eq("access_rsp_valid", rsp_valid, 1'b0);
            check_eq("access_cmd_ready", cmd_ready, 1'b0);
            if (k == waits) begin
                PREADY = 1'b1; PRDATA = rd; PSLVERR = er;
            end else begin
                PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
            end
            tick();
        end
        last_rdata = w ? 32'h0 : rd;
        last_err   = er;
        check_eq("rsp_valid", rsp_valid, 1'b1);
        check_eq("rsp_rdata", rsp_rdata, last_rdata);
        check_eq("rsp_err", rsp_err, last_err);
        check_eq("done_psel", PSEL, 1'b0);
        check_eq("done_penable", PENABLE, 1'b0);
        check_eq("done_cmd_ready", cmd_ready, 1'b1);
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
        tick();
        check_eq("rsp_pulse_end", rsp_valid, 1'b0);
        check_eq("rsp_rdata_hold", rsp_rdata, last_rdata);
        check_eq("rsp_err_hold", rsp_err, last_err);
        check_eq("idle_psel", PSEL, 1'b0);
        check_eq("idle_paddr_hold", PADDR, a);
        check_eq("idle_pwdata_hold", PWDATA, exp_wd);
        check_eq("idle_pwrite_hold", PWRITE, w);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        logic [ADDR_W-1:0] qa [5];
        logic [DATA_W-1:0] qd [5];
        int acc;
        int cyc;

        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        PREADY = 1'b0; PRDATA = 32'h0; PSLVERR = 1'b0;
        last_rdata = 32'h0; last_err = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        check_eq("rst_psel", PSEL, 1'b0);
        check_eq("rst_penable", PENABLE, 1'b0);
        check_eq("rst_pwrite", PWRITE, 1'b0);
        check_eq("rst_paddr", PADDR, 32'h0);
        check_eq("rst_pwdata", PWDATA, 32'h0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_rsp_err", rsp_err, 1'b0);
        PRESET = 1'b0;
        tick();
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);

        // Directed: write with no wait, read with 3 waits, error then clean write.
        do_xfer(1'b1, 32'h0000_1234, 32'h0000_ABCD, 0, 32'h0, 1'b0);
        do_xfer(1'b0, 32'h0000_0040, 32'h5555_5555, 3, 32'hDEAD_BEEF, 1'b0);
        do_xfer(1'b0, 32'h0000_0080, 32'h0, 1, 32'h1234_5678, 1'b1);
        do_xfer(1'b1, 32'h0000_0084, 32'hCAFE_F00D, 0, 32'h0, 1'b0);

        // Randomized transfers.
        for (int i = 0; i < 40; i++) begin
            do_xfer(1'($urandom), $urandom, $urandom, $urandom_range(0, 4), $urandom, 1'($urandom));
        end

        // Back-to-back writes with cmd_valid held and PREADY tied high.
        for (int i = 0; i < 5; i++) begin
            qa[i] = $urandom;
            qd[i] = $urandom;
        end
        PREADY = 1'b1; PSLVERR = 1'b0; cmd_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cmd_write = 1'b1; cmd_addr = qa[n]; cmd_wdata = qd[n];
            tick();
            check_eq("b2b_setup_penable", PENABLE, 1'b0);
            check_eq("b2b_setup_paddr", PADDR, qa[n]);
            check_eq("b2b_setup_pwdata", PWDATA, qd[n]);
            check_eq("b2b_setup_cmd_ready", cmd_ready, 1'b0);
            cmd_addr = $urandom; cmd_wdata = $urandom;
            tick();
            check_eq("b2b_access_penable", PENABLE, 1'b1);
            check_eq("b2b_access_paddr", PADDR, qa[n]);
            check_eq("b2b_access_cmd_ready", cmd_ready, 1'b0);
            tick();
            check_eq("b2b_rsp_valid", rsp_valid, 1'b1);
            check_eq("b2b_rsp_err", rsp_err, 1'b0);
            check_eq("b2b_rsp_rdata", rsp_rdata, 32'h0);
            check_eq("b2b_cmd_ready", cmd_ready, 1'b1);
        end
        cmd_valid = 1'b0;
        tick();
        check_eq("b2b_idle_psel", PSEL, 1'b0);

`ifdef APB_TIMEOUT_EN
        // PREADY arriving on the last permitted wait cycle is a normal completion.
        do_xfer(1'b0, 32'h0000_0100, 32'h0, TO - 1, 32'h0BAD_CAFE, 1'b0);
        // PREADY held low forever: abort after TO ACCESS cycles.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0200; PREADY = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        acc = 0;
        cyc = 0;
        while (!rsp_valid && cyc < 3 * TO) begin
            if (PENABLE) acc++;
            tick();
            cyc++;
        end
        check_eq("to_access_cycles", 64'(acc), 64'(TO));
        check_eq("to_rsp_valid", rsp_valid, 1'b1);
        check_eq("to_rsp_err", rsp_err, 1'b1);
        check_eq("to_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("to_cmd_ready", cmd_ready, 1'b1);
        check_eq("to_psel", PSEL, 1'b0);
        tick();
`endif

        // Reset in the middle of ACCESS: bus drops at once, no response ever.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0300; PREADY = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check_eq("pre_rst_penable", PENABLE, 1'b1);
        #2;
        PRESET = 1'b1;
        #1;
        check_eq("midrst_psel", PSEL, 1'b0);
        check_eq("midrst_penable", PENABLE, 1'b0);
        check_eq("midrst_rsp_valid", rsp_valid, 1'b0);
        PREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("inrst_rsp_valid", rsp_valid, 1'b0);
        end
        PRESET = 1'b0;
        PREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("postrst_rsp_valid", rsp_valid, 1'b0);
            check_eq("postrst_cmd_ready", cmd_ready, 1'b1);
            check_eq("postrst_paddr", PADDR, 32'h0);
            check_eq("postrst_psel", PSEL, 1'b0);
        end
        do_xfer(1'b1, 32'h0000_0400, 32'h1357_9BDF, 2, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
